// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write path.
// A write request is a (valid, dest, value) triple. Dest 0 is the hardwired zero register.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int STARVE_W   = 4;

    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     value;
    } wr_req_t;

    // A request only uses the write port when it targets a real register.
    function automatic logic isRealWrite(wr_req_t req);
        return req.valid && (req.dest != '0);
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of WB/MC requests, issue/query inputs and the register-file write outputs.
// master drives the requests; slave is the arbiter.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     wb_value;
    logic                  wb_ready;

    logic                  mc_valid;
    logic [REG_ADDR_W-1:0] mc_dest;
    logic [DATA_W-1:0]     mc_value;
    logic                  mc_ready;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_dest;
    logic [REG_ADDR_W-1:0] query_src1;
    logic [REG_ADDR_W-1:0] query_src2;
    logic                  src1_busy;
    logic                  src2_busy;

    logic                  write_en;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     write_value;
    logic                  err_double_issue;

    modport master (
        output wb_valid, wb_dest, wb_value,
        output mc_valid, mc_dest, mc_value,
        output issue_valid, issue_dest, query_src1, query_src2,
        input  wb_ready, mc_ready, src1_busy, src2_busy,
        input  write_en, dest, write_value, err_double_issue
    );

    modport slave (
        input  wb_valid, wb_dest, wb_value,
        input  mc_valid, mc_dest, mc_value,
        input  issue_valid, issue_dest, query_src1, query_src2,
        output wb_ready, mc_ready, src1_busy, src2_busy,
        output write_en, dest, write_value, err_double_issue
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Tracks which registers still await a multi-cycle result so decode can stall on them.
// Issue sets a bit, an accepted MC write clears it; a set beats a clear of the same register.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid_i,
    input  logic [REG_ADDR_W-1:0] set_dest_i,
    input  logic                  clr_valid_i,
    input  logic [REG_ADDR_W-1:0] clr_dest_i,
    input  logic [REG_ADDR_W-1:0] query1_i,
    input  logic [REG_ADDR_W-1:0] query2_i,
    output logic                  busy1_o,
    output logic                  busy2_o,
    output logic                  err_double_issue_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                err_q, err_d;
    logic                setHit, clrHit, sameReg;

    // Applying the clear before the set lets a simultaneous issue re-arm the bit.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        setHit    = set_valid_i && (set_dest_i != '0);
        clrHit    = clr_valid_i && (clr_dest_i != '0);
        sameReg   = clrHit && (clr_dest_i == set_dest_i);
        if (clrHit) begin
            pending_d[clr_dest_i] = 1'b0;
        end
        if (setHit) begin
            pending_d[set_dest_i] = 1'b1;
            if (pending_q[set_dest_i] && !sameReg) begin
                err_d = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign busy1_o            = pending_q[query1_i];
    assign busy2_o            = pending_q[query2_i];
    assign err_double_issue_o = err_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between writeback and the multi-cycle unit.
// WB normally wins a conflict; MC is forced through after STARVE_LIMIT consecutive refusals.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(STARVE_LIMIT);

    wr_req_t wbReq, mcReq;
    logic    wbLive, mcLive, conflict, mcForced;
    logic    wbReady, mcReady, wbWin, mcWin;

    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  writeEn_q, writeEn_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     value_q, value_d;

    assign wbReq = '{valid: bus.wb_valid, dest: bus.wb_dest, value: bus.wb_value};
    assign mcReq = '{valid: bus.mc_valid, dest: bus.mc_dest, value: bus.mc_value};

    // Dest-0 requests never compete, so they are always ready and never win the port.
    always_comb begin
        wbLive   = isRealWrite(wbReq);
        mcLive   = isRealWrite(mcReq);
        conflict = wbLive && mcLive;
        mcForced = (starve_q >= LIMIT_V);
        wbReady  = !(conflict && mcForced);
        mcReady  = !(conflict && !mcForced);
        wbWin    = wbLive && wbReady;
        mcWin    = mcLive && mcReady;
    end

    // A dest-0 MC request leaves the counter alone; only a real refusal counts as starvation.
    always_comb begin
        starve_d = starve_q;
        if (mcLive && !mcReady) begin
            if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (!mcReq.valid || mcLive) begin
            starve_d = '0;
        end
    end

    always_comb begin
        writeEn_d = wbWin || mcWin;
        dest_d    = dest_q;
        value_d   = value_q;
        if (mcWin) begin
            dest_d  = mcReq.dest;
            value_d = mcReq.value;
        end else if (wbWin) begin
            dest_d  = wbReq.dest;
            value_d = wbReq.value;
        end
    end

    // Reset drops any registered write that the register file has not committed yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q  <= '0;
            writeEn_q <= 1'b0;
            dest_q    <= '0;
            value_q   <= '0;
        end else begin
            starve_q  <= starve_d;
            writeEn_q <= writeEn_d;
            dest_q    <= dest_d;
            value_q   <= value_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk                (clk),
        .rst                (rst),
        .set_valid_i        (bus.issue_valid),
        .set_dest_i         (bus.issue_dest),
        .clr_valid_i        (mcWin),
        .clr_dest_i         (mcReq.dest),
        .query1_i           (bus.query_src1),
        .query2_i           (bus.query_src2),
        .busy1_o            (bus.src1_busy),
        .busy2_o            (bus.src2_busy),
        .err_double_issue_o (bus.err_double_issue)
    );

    assign bus.wb_ready    = wbReady;
    assign bus.mc_ready    = mcReady;
    assign bus.write_en    = writeEn_q;
    assign bus.dest        = dest_q;
    assign bus.write_value = value_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the arbitration rules.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state: what the DUT's registers must hold during the current cycle.
    bit          mPend [NUM_REGS];
    int          mStarve;
    bit          mWe;
    logic [4:0]  mDest;
    logic [31:0] mVal;
    bit          mErr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        foreach (mPend[i]) mPend[i] = 1'b0;
        mStarve = 0;
        mWe     = 1'b0;
        mDest   = '0;
        mVal    = '0;
        mErr    = 1'b0;
    endtask

    // Inputs are stable from posedge+2 to the next posedge, so mid-cycle is a safe sample point.
    always @(negedge clk) begin : compareProc
        bit wbLive, mcLive, wbGets, mcGets;
        int issueReg;
        if (rst) begin
            modelReset();
            checkOutput("rst write_en", bus.write_en, 0);
            checkOutput("rst dest", bus.dest, 0);
            checkOutput("rst write_value", bus.write_value, 0);
            checkOutput("rst src1_busy", bus.src1_busy, 0);
            checkOutput("rst src2_busy", bus.src2_busy, 0);
            checkOutput("rst err", bus.err_double_issue, 0);
        end else begin
            wbLive = bus.wb_valid && (bus.wb_dest != 0);
            mcLive = bus.mc_valid && (bus.mc_dest != 0);
            if (wbLive && mcLive) begin
                mcGets = (mStarve >= LIMIT);
                wbGets = !mcGets;
            end else begin
                wbGets = wbLive;
                mcGets = mcLive;
            end
            if (bus.wb_valid) checkOutput("wb_ready", bus.wb_ready, (!wbLive || wbGets) ? 1 : 0);
            if (bus.mc_valid) checkOutput("mc_ready", bus.mc_ready, (!mcLive || mcGets) ? 1 : 0);
            checkOutput("src1_busy", bus.src1_busy, mPend[bus.query_src1]);
            checkOutput("src2_busy", bus.src2_busy, mPend[bus.query_src2]);
            checkOutput("write_en", bus.write_en, mWe);
            checkOutput("dest", bus.dest, mDest);
            checkOutput("write_value", bus.write_value, mVal);
            checkOutput("err_double_issue", bus.err_double_issue, mErr);

            if (mcLive && !mcGets) mStarve = (mStarve < 15) ? mStarve + 1 : 15;
            else if (!bus.mc_valid || mcLive) mStarve = 0;

            issueReg = int'(bus.issue_dest);
            if (bus.issue_valid && issueReg != 0 && mPend[issueReg]
                && !(mcGets && int'(bus.mc_dest) == issueReg)) mErr = 1'b1;
            if (mcGets) mPend[bus.mc_dest] = 1'b0;
            if (bus.issue_valid && issueReg != 0) mPend[issueReg] = 1'b1;

            mWe = wbGets || mcGets;
            if (mcGets) begin
                mDest = bus.mc_dest;
                mVal  = bus.mc_value;
            end else if (wbGets) begin
                mDest = bus.wb_dest;
                mVal  = bus.wb_value;
            end
        end
    end

    // Drives one cycle's inputs just after posedge and returns mid-cycle of that same cycle.
    task automatic applyStimulus(input logic rstV,
                                 input logic wbV, input logic [4:0] wbD, input logic [31:0] wbX,
                                 input logic mcV, input logic [4:0] mcD, input logic [31:0] mcX,
                                 input logic isV, input logic [4:0] isD,
                                 input logic [4:0] q1, input logic [4:0] q2);
        @(posedge clk);
        #2;
        rst             = rstV;
        bus.wb_valid    = wbV;
        bus.wb_dest     = wbD;
        bus.wb_value    = wbX;
        bus.mc_valid    = mcV;
        bus.mc_dest     = mcD;
        bus.mc_value    = mcX;
        bus.issue_valid = isV;
        bus.issue_dest  = isD;
        bus.query_src1  = q1;
        bus.query_src2  = q2;
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : stimulus
        bit          expW [6];
        bit          expM [6];
        logic        wbV, mcV, isV;
        logic [4:0]  wbD, mcD, isD;
        logic [31:0] wbX, mcX;
        expW = '{1, 1, 1, 1, 0, 1};
        expM = '{0, 0, 0, 0, 1, 0};

        rst = 1'b1;
        bus.wb_valid = 0; bus.wb_dest = 0; bus.wb_value = 0;
        bus.mc_valid = 0; bus.mc_dest = 0; bus.mc_value = 0;
        bus.issue_valid = 0; bus.issue_dest = 0;
        bus.query_src1 = 9; bus.query_src2 = 12;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("lit reset write_en", bus.write_en, 0);
        checkOutput("lit reset dest", bus.dest, 0);
        checkOutput("lit reset value", bus.write_value, 0);
        checkOutput("lit reset busy1", bus.src1_busy, 0);

        applyStimulus(0, 1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lit wb alone ready", bus.wb_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lit first write_en", bus.write_en, 1);
        checkOutput("lit first dest", bus.dest, 3);
        checkOutput("lit first value", bus.write_value, 32'h55);

        // Continuous conflict: four WB wins, one forced MC win, then WB again.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 5, 32'hAAAA, 1, 6, 32'hBBBB, 0, 0, 0, 0);
            checkOutput($sformatf("lit starve wb_ready k%0d", k), bus.wb_ready, expW[k]);
            checkOutput($sformatf("lit starve mc_ready k%0d", k), bus.mc_ready, expM[k]);
        end
        checkOutput("lit starve mc dest", bus.dest, 6);
        checkOutput("lit starve mc value", bus.write_value, 32'hBBBB);
        applyStimulus(0, 0, 0, 0, 1, 6, 32'hBBBB, 0, 0, 0, 0);
        checkOutput("lit starve mc alone ready", bus.mc_ready, 1);
        checkOutput("lit starve wb after", bus.dest, 5);

        applyStimulus(0, 1, 0, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0);
        checkOutput("lit dest0 wb_ready", bus.wb_ready, 1);
        checkOutput("lit dest0 mc_ready", bus.mc_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lit dest0 write_en", bus.write_en, 1);
        checkOutput("lit dest0 dest", bus.dest, 7);
        checkOutput("lit dest0 value", bus.write_value, 32'h77);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        checkOutput("lit r9 busy after issue", bus.src1_busy, 1);
        applyStimulus(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
        checkOutput("lit r9 busy in accept cycle", bus.src1_busy, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        checkOutput("lit r9 busy cleared", bus.src1_busy, 0);
        checkOutput("lit r9 write dest", bus.dest, 9);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 12);
        applyStimulus(0, 0, 0, 0, 1, 12, 32'hC, 1, 12, 0, 12);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("lit r12 still pending", bus.src2_busy, 1);
        checkOutput("lit r12 no err", bus.err_double_issue, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 12);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("lit r12 err set", bus.err_double_issue, 1);
        applyStimulus(0, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("lit r12 err sticky", bus.err_double_issue, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("lit pre-reset write_en", bus.write_en, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("lit async reset write_en", bus.write_en, 0);
        checkOutput("lit async reset busy2", bus.src2_busy, 0);
        checkOutput("lit async reset err", bus.err_double_issue, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; a refused request is held until it is accepted.
        wbV = 0; wbD = 0; wbX = 0; mcV = 0; mcD = 0; mcX = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.wb_valid || bus.wb_ready || rst) begin
                wbV = ($urandom_range(0, 3) != 0);
                wbD = 5'($urandom_range(0, 7));
                wbX = $urandom;
            end
            if (!bus.mc_valid || bus.mc_ready || rst) begin
                mcV = ($urandom_range(0, 2) != 0);
                mcD = 5'($urandom_range(0, 7));
                mcX = $urandom;
            end
            isV = ($urandom_range(0, 3) == 0);
            isD = 5'($urandom_range(0, 7));
            applyStimulus((c == 1500 || c == 1501), wbV, wbD, wbX, mcV, mcD, mcX, isV, isD,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
